// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch core.
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam int   DIGITS  = 4;
endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter: wraps at MAX and reports carry on the wrapping increment.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  assign carry = inc & (q == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == MAX) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Stopwatch core SS.hh: run/pause FSM, ms prescaler, BCD digit chain, sticky wrap flag.
// Optional lap/display hold enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICK_MS      = 10,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_1ms,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] digits,
  output logic        running,
  output logic        ovf
);

  // TICK_MS=1 would give a zero-width prescaler; keep at least one bit.
  localparam int PW = (TICK_MS > 1) ? $clog2(TICK_MS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_MS - 1);

  sw_state_t         state;
  logic [PW-1:0]     presc;
  logic [DIGITS:0]   inc;
  bcd_t              cnt [DIGITS];
  logic [15:0]       live;

  // Counting uses the state held at this edge, so a start_stop in the same cycle
  // lets a RUN tick through but blocks a tick while leaving PAUSE/IDLE.
  assign inc[0] = (state == RUN) & ce_1ms & ~clear & (presc == PRE_MAX);
  assign live   = {cnt[3], cnt[2], cnt[1], cnt[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (start_stop) begin
      case (state)
        RUN: begin
          state   <= PAUSE;
          running <= 1'b0;
        end
        default: begin
          state   <= RUN;
          running <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if ((state == RUN) && ce_1ms) begin
      presc <= (presc == PRE_MAX) ? '0 : presc + 1'b1;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cnt #(
      .MAX((i == DIGITS - 1) ? bcd_t'(SEC_TENS_MAX) : BCD_MAX)
    ) u_digit (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clear),
      .inc  (inc[i]),
      .q    (cnt[i]),
      .carry(inc[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (clear) begin
      ovf <= 1'b0;
    end else if (inc[DIGITS]) begin
      ovf <= 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        hold;
  logic [15:0] disp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= 1'b0;
    end else if (clear) begin
      hold <= 1'b0;
    end else if (lap && (state != IDLE)) begin
      hold <= ~hold;
    end
  end

  // Snapshot taken on the lap pulse that turns hold on.
  always_ff @(posedge clk) begin
    if (!clear && lap && (state != IDLE) && !hold) begin
      disp <= live;
    end
  end

  assign digits = hold ? disp : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign digits     = live;
`endif

endmodule
